// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encodings.
package restoring_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/restoring_divider_addsub_ripple.sv
// Parameterised ripple-carry adder/subtractor built from one-bit slices.
// select=1 inverts b so that a + ~b + cin gives a - b when cin=1; cout=1 then means no borrow.
module addsub_ripple #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             select,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] b_eff;

   assign carry[0] = cin;
   assign b_eff    = b ^ {WIDTH{select}};

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, MSB first.
// Optional macro DIVIDER_ZERO_CHECK_EN short-circuits a zero divisor straight to DONE.
module restoring_divider
   import restoring_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem, dvd, dsr, q_sh;
   logic [WIDTH:0]   shifted, trial;
   logic             no_borrow, take, accept;
   logic [WIDTH-1:0] rem_next, q_next;

   assign accept  = start && (state == IDLE || state == DONE);
   assign shifted = {rem, dvd[WIDTH-1]};

   addsub_ripple #(.WIDTH(WIDTH + 1)) u_trial (
      .a      (shifted),
      .b      ({1'b0, dsr}),
      .select (1'b1),
      .cin    (1'b1),
      .sum    (trial),
      .cout   (no_borrow)
   );

   // The partial remainder stays below the divisor, so trial[WIDTH] is clear whenever there is no borrow.
   assign take     = no_borrow & ~trial[WIDTH];
   assign rem_next = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign q_next   = {q_sh[WIDTH-2:0], take};

   always_ff @(posedge clk) begin
      if (accept) begin
         dvd  <= dividend;
         dsr  <= divisor;
         rem  <= '0;
         q_sh <= '0;
      end else if (state == RUN) begin
         dvd  <= {dvd[WIDTH-2:0], 1'b0};
         rem  <= rem_next;
         q_sh <= q_next;
      end
   end

`ifndef DIVIDER_ZERO_CHECK_EN
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
`ifdef DIVIDER_ZERO_CHECK_EN
                  if (divisor == '0) begin
                     state       <= DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= RUN;
                     cnt   <= CNT_W'(WIDTH);
                     busy  <= 1'b1;
                  end
`else
                  state <= RUN;
                  cnt   <= CNT_W'(WIDTH);
                  busy  <= 1'b1;
`endif
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= q_next;
                  remainder   <= rem_next;
`ifdef DIVIDER_ZERO_CHECK_EN
                  div_by_zero <= 1'b0;
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (WIDTH=8) with directed, hand-computed vectors.
module tb_restoring_divider;

   localparam int W = 8;
`ifdef DIVIDER_ZERO_CHECK_EN
   localparam int   ZLAT  = 1;
   localparam logic ZFLAG = 1'b1;
`else
   localparam int   ZLAT  = 8;
   localparam logic ZFLAG = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
      int           t0;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("quotient", 32'(quotient), 32'(mon_e.q));
            check("remainder", 32'(remainder), 32'(mon_e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(mon_e.z));
            check("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
   endtask

   task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input int lat);
      sb.push_back('{q: q, r: r, z: z, lat: lat, t0: cyc});
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (done === 1'b1);
      end
      check("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic z, input int lat);
      issue(a, b);
      @(posedge clk); #1;
      start = 1'b0;
      push(q, r, z, lat);
      wait_done();
      @(posedge clk); #1;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      @(posedge clk); #1;

      // 100/7 with a look at busy in the first RUN cycle
      issue(8'd100, 8'd7);
      @(posedge clk); #1;
      start = 1'b0;
      push(8'd14, 8'd2, 1'b0, 8);
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
      check("done_in_run", 32'(done), 32'd0);
      wait_done();
      @(posedge clk); #1;

      run_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8);
      run_div(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8);
      run_div(8'd200, 8'd13,  8'd15,  8'd5,   1'b0, 8);
      run_div(8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 8);
      run_div(8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8);
      run_div(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 8);
      run_div(8'd77,  8'd0,   8'd255, 8'd77,  ZFLAG, ZLAT);

      // start during RUN is ignored; start in the DONE cycle is accepted
      issue(8'd100, 8'd7);
      @(posedge clk); #1;
      start = 1'b0;
      push(8'd14, 8'd2, 1'b0, 8);
      repeat (2) @(posedge clk);
      #1 issue(8'd50, 8'd3);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      issue(8'd50, 8'd3);
      @(posedge clk); #1;
      start = 1'b0;
      push(8'd16, 8'd2, 1'b0, 8);
      wait_done();
      @(posedge clk); #1;

      // reset during the 4th RUN cycle discards the division
      issue(8'd10, 8'd3);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_quotient", 32'(quotient), 32'd0);
      check("midrst_remainder", 32'(remainder), 32'd0);
      check("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
      repeat (15) @(negedge clk);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (minimum 2).
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: request to begin a division.
REQ-005 Port dividend, input, WIDTH bits: unsigned dividend, sampled on the edge that accepts start.
REQ-006 Port divisor, input, WIDTH bits: unsigned divisor, sampled on the edge that accepts start.
REQ-007 Port busy, output, 1 bit: high while a division is in progress.
REQ-008 Port done, output, 1 bit: one-cycle pulse; quotient and remainder are valid.
REQ-009 Port quotient, output, WIDTH bits: result quotient.
REQ-010 Port remainder, output, WIDTH bits: result remainder.
REQ-011 Port div_by_zero, output, 1 bit: the last result came from a zero divisor.

Function
REQ-012 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; an accepted start latches both operands and enters RUN with the iteration counter set to WIDTH.
REQ-014 start SHALL be ignored in RUN; the operands in flight are unaffected.
REQ-015 Each RUN cycle:
- shift the partial remainder left, inserting the next dividend bit (MSB first);
- form trial = partial - divisor on a WIDTH+1-bit subtractor;
- if there is no borrow, keep trial and shift in quotient bit 1;
- otherwise restore the partial remainder and shift in 0.
REQ-016 When the last RUN iteration completes, the block SHALL enter DONE.
- Start accepted on edge k: busy=1 during the cycles after edges k through k+WIDTH-1.
- done=1 and busy=0 during the single cycle after edge k+WIDTH.
REQ-017 DONE SHALL last exactly one cycle and then go to IDLE, unless start is accepted in that cycle, in which case it goes to RUN.
REQ-018 quotient, remainder and div_by_zero SHALL update only on the entry to DONE and SHALL hold until the next entry to DONE.
REQ-019 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every non-zero divisor.
REQ-020 A zero divisor SHALL give quotient = all ones and remainder = dividend.

Reset
REQ-021 rst high on an edge SHALL force IDLE and set busy, done, quotient, remainder and div_by_zero to 0, regardless of state; rst has priority over start.
REQ-022 A division in progress when rst is asserted SHALL be discarded and no done pulse produced.

Configuration
REQ-023 Macro DIVIDER_ZERO_CHECK_EN SHALL control zero-divisor detection.
- Defined: a zero divisor detected at start acceptance goes directly to DONE on the next edge, so done follows 1 cycle after start. div_by_zero=1 and the REQ-020 results apply.
- Undefined: a zero divisor runs the full WIDTH iterations and naturally yields the REQ-020 results. div_by_zero is tied to 0 and no detection logic is present.

Structure
REQ-024 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL reside in the shared definitions include file, not locally.
REQ-025 The trial subtraction SHALL be a sub-module addsub_ripple.
- Parameterised width, ripple chain of one-bit add/sub slices.
- Inputs a, b, select (1 = subtract), cin; outputs sum and cout.
- The divider instantiates it with select=1 and cin=1.

Verification (WIDTH=8)
REQ-026 100/7 -> on the 8th edge after start: done=1, quotient=14, remainder=2, div_by_zero=0.
REQ-027 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5.
REQ-028 Divisor 0 with dividend 77:
- With the macro: done 1 cycle after start, div_by_zero=1, quotient=255, remainder=77.
- Without the macro: done after 8 cycles, same quotient and remainder, div_by_zero=0.
REQ-029 start pulsed with 50/3 during RUN of 100/7 -> it is ignored; results are 14/2. Then start 50/3 in the DONE cycle -> the next done gives 16/2.
REQ-030 rst asserted on the 4th RUN cycle -> on the next cycle busy=0, and all outputs are 0. No done follows.
